// File: rtl/aes_pkg.sv
// AES-128 constants and round-level helper functions (S-box, GF(2^8) math,
// SubBytes/ShiftRows/MixColumns, one key-schedule step).
package aes_pkg;

  localparam int NB = 4;
  localparam int NK = 4;
  localparam int NR = 10;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Byte (r,c) sits at index 4*c+r counted from the MSB end.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % NB) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < NB; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 32] = {gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                             a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                             a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
                             gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)};
    end
    return o;
  endfunction

  // Next round key from the previous one: RotWord/SubWord/Rcon on the last word, then chain.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rcon, 24'h000000};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes128_iter_encrypt_if.sv
// Plaintext/key in, state/done out for the iterative AES-128 core.
interface aes128_iter_encrypt_if;
  logic [127:0] data;
  logic [127:0] key;
  logic [127:0] state;
  logic         done;

  modport master (output data, output key, input state, input done);
  modport slave  (input data, input key, output state, output done);
endinterface

// File: rtl/aes128_key_expand.sv
// Combinational AES-128 key schedule; round key Ki lands at o_round_keys[128*i +: 128].
module aes128_key_expand #(
  parameter int KE_NK = aes_pkg::NK,
  parameter int KE_NR = aes_pkg::NR
) (
  input  logic [32*KE_NK-1:0]       i_key,
  output logic [(KE_NR+1)*128-1:0]  o_round_keys
);

  for (genvar r = 0; r <= KE_NR; r++) begin : g_rk
    logic [127:0] w_key;
    if (r == 0) begin : g_first
      assign w_key = i_key;
    end else begin : g_next
      assign w_key = aes_pkg::key_step(g_rk[r-1].w_key, aes_pkg::RCON[r-1]);
    end
    assign o_round_keys[128*r +: 128] = w_key;
  end

endmodule

// File: rtl/aes128_iter_encrypt.sv
// Iterative AES-128 encryptor: one round per clock, ciphertext 11 edges after reset.
// No handshake: a synchronous reset loads the plaintext and restarts the sequence.
module aes128_iter_encrypt #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  aes128_iter_encrypt_if.slave        bus
);

  localparam logic [3:0] RC_LAST = 4'(NR + 1);
  localparam logic [3:0] RC_DONE = 4'(NR + 2);

  // Power-up idle: rc parked at the finished value with done low.
  logic [127:0] r_state = '0;
  logic [3:0]   r_rc    = RC_DONE;
  logic         r_done  = 1'b0;

  logic [(NR+1)*128-1:0] w_round_keys;
  logic [127:0]          w_sr;
  logic [127:0]          w_mc;
  logic [127:0]          w_rk;
  logic [127:0]          w_next;

  aes128_key_expand #(
    .KE_NK (NK),
    .KE_NR (NR)
  ) u_key_expand (
    .i_key        (bus.key),
    .o_round_keys (w_round_keys)
  );

  always_comb begin
    w_sr = aes_pkg::shift_rows(aes_pkg::sub_bytes(r_state));
    w_mc = aes_pkg::mix_columns(w_sr);
    w_rk = '0;
    // Step rc consumes round key K(rc-1).
    for (int i = 0; i <= NR; i++) begin
      if (r_rc == 4'(i + 1)) w_rk = w_round_keys[128*i +: 128];
    end
    if (r_rc == 4'd1)         w_next = r_state ^ w_rk;
    else if (r_rc == RC_LAST) w_next = w_sr ^ w_rk;
    else                      w_next = w_mc ^ w_rk;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= bus.data;
      r_rc    <= 4'd1;
      r_done  <= 1'b0;
    end else if (r_rc != RC_DONE) begin
      r_state <= w_next;
      r_rc    <= r_rc + 4'd1;
      r_done  <= (r_rc == RC_LAST);
    end
  end

  assign bus.state = r_state;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_aes128_iter_encrypt.sv
// Scoreboarded bench for aes128_iter_encrypt against a byte-level AES reference model.
module tb_aes128_iter_encrypt;

  localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_D  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_E1 = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] C1_E2 = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_D   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk;
  logic reset;
  aes128_iter_encrypt_if bus();

  aes128_iter_encrypt #(.NK(4), .NR(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] sb_q[$];
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   m_sbox [256];
  logic [127:0] m_rk   [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      m_sbox[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic void expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) w[i] = key[127 - 32*i -: 32];
      else begin
        t = w[i-1];
        if (i % 4 == 0) begin
          t = {m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]], m_sbox[t[31:24]]} ^ {rcon, 24'h0};
          rcon = gmul(rcon, 8'h02);
        end
        w[i] = w[i-4] ^ t;
      end
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // State after n update edges following reset (n = 0..11).
  function automatic logic [127:0] ref_after(input logic [127:0] key, input logic [127:0] data, input int n);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] st;
    expand_key(key);
    for (int i = 0; i < 16; i++) s[i] = data[127 - 8*i -: 8];
    for (int step = 1; step <= n; step++) begin
      if (step > 1) begin
        for (int i = 0; i < 16; i++) s[i] = m_sbox[s[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
        if (step <= 10) begin
          for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = t[r + 4*c];
            for (int r = 0; r < 4; r++)
              s[r + 4*c] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
          end
        end else s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ m_rk[step-1][127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = s[i];
    return st;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.done && !prev_done) begin
      if (sb_q.size() == 0) check("unexpected_done", 128'(1), 128'(0));
      else check("ciphertext", bus.state, sb_q.pop_front());
    end
    prev_done <= bus.done;
  end

  // ---------------- stimulus ----------------
  task automatic run_enc(input logic [127:0] k, input logic [127:0] d, input int rst_cycles,
                         input logic [127:0] exp_ct, input logic [127:0] exp1, input logic [127:0] exp2);
    int edges;
    bus.key  = k;
    bus.data = d;
    reset    = 1'b1;
    for (int i = 0; i < rst_cycles; i++) begin
      tick();
      check("reset_state", bus.state, d);
      check("reset_done", 128'(bus.done), 128'(0));
    end
    reset = 1'b0;
    sb_q.push_back(exp_ct);
    tick();
    check("e1_state", bus.state, exp1);
    tick();
    check("e2_state", bus.state, exp2);
    edges = 2;
    while (!bus.done && edges < 20) begin
      tick();
      edges++;
    end
    check("latency_edges", 128'(edges), 128'(11));
  endtask

  task automatic run_abort(input logic [127:0] k, input logic [127:0] d, input int abort_edge,
                           input logic [127:0] exp_ct);
    bus.key  = k;
    bus.data = d;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    repeat (abort_edge - 1) tick();
    check("abort_mid_state", bus.state, ref_after(k, d, abort_edge - 1));
    check("abort_mid_done", 128'(bus.done), 128'(0));
    run_enc(k, d, 1, exp_ct, ref_after(k, d, 1), ref_after(k, d, 2));
  endtask

  initial begin
    logic [127:0] k, d;
    reset    = 1'b0;
    bus.key  = '0;
    bus.data = '0;
    build_sbox();
    #1;
    check("powerup_state", bus.state, 128'h0);
    check("powerup_done", 128'(bus.done), 128'(0));
    repeat (3) tick();
    check("idle_state", bus.state, 128'h0);
    check("idle_done", 128'(bus.done), 128'(0));

    check("mixcol_c0", aes_pkg::mix_columns(128'hdb135345f20a225c0000000000000000) & {64'hffffffffffffffff, 64'h0},
          128'h8e4da1bc9fdc589d0000000000000000);

    run_enc(C1_K, C1_D, 1, C1_CT, C1_E1, C1_E2);
    check("c1_state_final", bus.state, C1_CT);
    check("c1_done", 128'(bus.done), 128'(1));
    check("c1_k1", dut.w_round_keys[255:128], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check("c1_k10", dut.w_round_keys[1407:1280], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    run_enc(B_K, B_D, 1, B_CT, ref_after(B_K, B_D, 1), ref_after(B_K, B_D, 2));
    bus.data = {$urandom, $urandom, $urandom, $urandom};
    bus.key  = {$urandom, $urandom, $urandom, $urandom};
    repeat (5) tick();
    check("b_hold_state", bus.state, B_CT);
    check("b_hold_done", 128'(bus.done), 128'(1));

    run_enc(C1_K, C1_D, 3, C1_CT, C1_E1, C1_E2);
    run_abort(C1_K, C1_D, 5, C1_CT);

    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      run_enc(k, d, int'($urandom_range(1, 3)), ref_after(k, d, 11), ref_after(k, d, 1), ref_after(k, d, 2));
    end
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      run_abort(k, d, int'($urandom_range(1, 10)), ref_after(k, d, 11));
    end

    repeat (2) tick();
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes128_iter_encrypt.md
# aes128_iter_encrypt

Iterative AES-128 encryption core: one round per clock over a 128-bit state register, with the full key schedule expanded combinationally from the cipher key. It sits between the key/plaintext source and the ciphertext consumer. It folds the SubBytes, ShiftRows, MixColumns, AddRoundKey and KeyExpansion functions into one clocked block. Byte order follows FIPS-197: bits [127:120] are byte 0, the state is column-major, and bytes 0–3 form column 0.

## Interface
- NK, default 4: key length in 32-bit words. Only 4 is supported.
- NR, default 10: number of rounds. Only 10 is supported.
- clk, input, 1: single clock. All state updates occur on its rising edge.
- reset, input, 1: synchronous, active-high. Loads the plaintext and restarts the round sequence.
- data, input, 128: plaintext. Must be held stable from reset through done.
- key, input, 128: cipher key. Must be held stable from reset through done.
- state, output, 128: registered AES state. Equals the ciphertext once done=1.
- done, output, 1: registered. High when all rounds are complete.

## Operation
- Internal registers:
  - state[127:0]
  - round counter rc[3:0], range 1..12 (12 means finished)
- Key schedule: combinational, per FIPS-197 §5.2, producing round keys K0..K10.
  - Generates words w0..w43; Ki = {w4i, w4i+1, w4i+2, w4i+3}.
  - K0 = key. Rcon = 01,02,04,08,10,20,40,80,1b,36.
- Each step with rc≤11 computes next_state from state and loads it:
  - rc=1: next = state ^ K0 (initial AddRoundKey).
  - rc=2..10: next = MixColumns(ShiftRows(SubBytes(state))) ^ K(rc−1).
  - rc=11: next = ShiftRows(SubBytes(state)) ^ K10 (no MixColumns).
  - rc increments by 1.
- rc=12: state and rc hold. done=1.
- MixColumns per column uses the fixed matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02] over GF(2^8).
  - Reduction polynomial 0x11b; xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
- ShiftRows: row r is rotated left by r bytes.
- SubBytes: standard AES S-box applied to all 16 bytes. Implemented as a constant table or as GF inverse plus affine transform.
- All arithmetic is bitwise XOR within bytes; there is no carry.

## Timing
- Reset (reset=1 at a rising edge): state ← data, rc ← 1, done ← 0. Reset has priority over round stepping in the same cycle.
- Power-up values before the first reset: state=0, rc=12, done=0 (idle).
- Latency: with reset sampled at edge E0, the 11 round updates occur at edges E1..E11.
  - state holds the ciphertext after E11.
  - done rises after E11.
- After E1, state = data ^ K0.
- After En (n=2..10), state is the output of FIPS round n−1.
- Reset asserted mid-operation aborts the current encryption and restarts from the current data.
- Reset held high for multiple cycles keeps state=data and rc=1.
- Changing data or key between reset and done is unsupported; the result is then undefined. Changing them while done=1 has no effect until the next reset.
- No input handshake. Only a new reset starts a new encryption.

## Structure
- Package aes_pkg holds:
  - S-box constant/function
  - xtime and gf_mul2/gf_mul3 functions
  - Rcon constant array
  - NB=4, NK=4, NR=10 constants
- One sub-module: aes128_key_expand (key[127:0] → round_keys[11*128-1:0], Ki at slice [128*i +: 128]), purely combinational.
- Round datapath functions (sub_bytes, shift_rows, mix_columns) live in the package as functions and are instantiated inline in the top.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, one reset cycle.
  - After E1, state = 00102030405060708090a0b0c0d0e0f0.
  - After E2, state = 89d810e8855ace682d1843d8cb128fe4.
  - After E11, state = 69c4e0d86a7b0430d8cdb78070b4c55a and done=1.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734.
  - After E11, state = 3925841d02dc09fbdc118597196a0b32.
  - state is still that value 5 cycles later.
- Key schedule (C.1 key): K10 = 13111d7fe3944a17f307a78b4d2b30c5; K1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
- MixColumns column check: a state whose column 0 is db135345 passes through MixColumns with column 0 = 8e4da1bc. Column f20a225c maps to 9fdc589d.
- Reset mid-operation: run C.1 and assert reset at E5.
  - state = data and done=0 on the next cycle.
  - The ciphertext appears exactly 11 edges after the reset edge.
- Reset held high 3 cycles: state stays 00112233445566778899aabbccddeeff and done=0 throughout.
